// File: rtl/adc_read_ctrl.sv
// Read controller for a parallel-bus multichannel ADC: starts a conversion,
// follows BUSY, then strobes CS_N/RD_N once per channel and presents each word.
module adc_read_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int CONV_CYC  = 2,
    parameter int RD_LO_CYC = 1,
    parameter int RD_HI_CYC = 1,
    parameter int QUIET_CYC = 4,
    parameter int BUSY_TO   = 64
) (
    input  logic        XCLK,
    input  logic        RST,
    input  logic        START,
    input  logic        BUSY,
    input  logic [15:0] DB,
    output logic        CONVST_A,
    output logic        CONVST_B,
    output logic        CONVST_C,
    output logic        CONVST_D,
    output logic        CS_N,
    output logic        RD_N,
    output logic        WR_N,
    output logic [15:0] SAMPLE_DATA,
    output logic [2:0]  SAMPLE_CH,
    output logic        SAMPLE_VALID,
    output logic        FRAME_DONE,
    output logic        TIMEOUT_ERR,
    output logic        READY
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONV    = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_RD_LO   = 3'd4;
    localparam logic [2:0] S_RD_HI   = 3'd5;
    localparam logic [2:0] S_QUIET   = 3'd6;

    localparam int CNT_W = 16;

    // Zero-length phases are clamped to one cycle so the "last cycle" compare never wraps.
    localparam int CONV_EFF  = (CONV_CYC  < 1) ? 1 : CONV_CYC;
    localparam int RDLO_EFF  = (RD_LO_CYC < 1) ? 1 : RD_LO_CYC;
    localparam int RDHI_EFF  = (RD_HI_CYC < 1) ? 1 : RD_HI_CYC;
    localparam int QUIET_EFF = (QUIET_CYC < 1) ? 1 : QUIET_CYC;
    localparam int TO_EFF    = (BUSY_TO   < 1) ? 1 : BUSY_TO;

    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_EFF - 1);
    localparam logic [CNT_W-1:0] RDLO_LAST  = CNT_W'(RDLO_EFF - 1);
    localparam logic [CNT_W-1:0] RDHI_LAST  = CNT_W'(RDHI_EFF - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_EFF - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TO_EFF - 1);
    localparam logic [2:0]       LAST_CH    = 3'(NUM_CH - 1);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cyc_cnt;
    logic [2:0]       ch_cnt;
    logic             busy_meta;
    logic             busy_s;
    logic             capture;
    logic             frame_end;
    logic             timeout;
    logic             ch_inc;
    logic             ch_clr;
    logic             conv_on;

    // Strobes decode straight from the state register so reset clears them without waiting for a clock.
    assign conv_on  = (state == S_CONV);
    assign CONVST_A = conv_on;
    assign CONVST_B = conv_on;
    assign CONVST_C = conv_on;
    assign CONVST_D = conv_on;
    assign CS_N     = !((state == S_RD_LO) || (state == S_RD_HI));
    assign RD_N     = (state != S_RD_LO);
    assign WR_N     = 1'b1;
    assign READY    = (state == S_IDLE);

    always_ff @(posedge XCLK or posedge RST) begin
        if (RST) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
        end else begin
            busy_meta <= BUSY;
            busy_s    <= busy_meta;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        frame_end  = 1'b0;
        timeout    = 1'b0;
        ch_inc     = 1'b0;
        ch_clr     = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) state_next = S_CONV;
            end
            S_CONV: begin
                if (cyc_cnt >= CONV_LAST) state_next = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (busy_s) begin
                    state_next = S_WAIT_LO;
                end else if (cyc_cnt >= TO_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_WAIT_LO: begin
                if (!busy_s) begin
                    ch_clr     = 1'b1;
                    state_next = S_RD_LO;
                end else if (cyc_cnt >= TO_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_RD_LO: begin
                if (cyc_cnt >= RDLO_LAST) begin
                    capture    = 1'b1;
                    state_next = S_RD_HI;
                end
            end
            S_RD_HI: begin
                if (cyc_cnt >= RDHI_LAST) begin
                    if (ch_cnt < LAST_CH) begin
                        ch_inc     = 1'b1;
                        state_next = S_RD_LO;
                    end else begin
                        frame_end  = 1'b1;
                        state_next = S_QUIET;
                    end
                end
            end
            S_QUIET: begin
                if (cyc_cnt >= QUIET_LAST) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Cycle counter restarts on every state change (including RD_HI->RD_LO) and saturates otherwise.
    always_ff @(posedge XCLK or posedge RST) begin
        if (RST) begin
            state        <= S_IDLE;
            cyc_cnt      <= '0;
            ch_cnt       <= '0;
            SAMPLE_DATA  <= '0;
            SAMPLE_CH    <= '0;
            SAMPLE_VALID <= 1'b0;
            FRAME_DONE   <= 1'b0;
            TIMEOUT_ERR  <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cyc_cnt <= '0;
            end else if (cyc_cnt != {CNT_W{1'b1}}) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            if (ch_clr) begin
                ch_cnt <= '0;
            end else if (ch_inc) begin
                ch_cnt <= ch_cnt + 1'b1;
            end
            SAMPLE_VALID <= capture;
            if (capture) begin
                SAMPLE_DATA <= DB;
                SAMPLE_CH   <= ch_cnt;
            end
            FRAME_DONE  <= frame_end;
            TIMEOUT_ERR <= timeout;
        end
    end

endmodule
